// File: rtl/bf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bf_pkg
//  Purpose  : Shared types for the parametrised tape-machine core. Defines the
//             3-bit program opcode encoding and the core control states.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package bf_pkg;

  localparam int c_OPCODE_W = 3;

  // Opcode encoding as stored in program ROM.
  typedef enum logic [c_OPCODE_W-1:0] {
    OP_INC   = 3'd0,  // '+'
    OP_DEC   = 3'd1,  // '-'
    OP_RIGHT = 3'd2,  // '>'
    OP_LEFT  = 3'd3,  // '<'
    OP_LOOP  = 3'd4,  // '['
    OP_END   = 3'd5,  // ']'
    OP_OUT   = 3'd6,  // '.'
    OP_IN    = 3'd7   // ','
  } opcode_t;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_EXEC      = 3'd1,
    ST_SKIP_FWD  = 3'd2,
    ST_SKIP_BACK = 3'd3,
    ST_OUT_WAIT  = 3'd4,
    ST_IN_WAIT   = 3'd5,
    ST_HALT      = 3'd6,
    ST_ERROR     = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bf_loop_stack.sv
`default_nettype none
// ============================================================================
//  Module   : bf_loop_stack
//  Purpose  : LIFO of loop-start program addresses. Holds the pc of each
//             entered '[' so that ']' can jump back in a single cycle.
//  Ports    : clock, reset_n (async, active low -> empty)
//             push, push_data : store push_data on top (ignored when full)
//             pop             : discard top entry (ignored when empty)
//             top             : current top entry (0 when empty)
//             full, empty     : occupancy flags
//  Revision : 1.0 - initial release
// ============================================================================
module bf_loop_stack #(
  parameter int PC_W  = 16,
  parameter int DEPTH = 16   // power of 2, >= 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0] r_mem [DEPTH];
  logic [c_AW:0]   r_count;
  logic [c_AW-1:0] w_top_idx;

  assign w_top_idx = c_AW'(r_count - 1'b1);
  assign full      = (r_count == (c_AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign top       = empty ? '0 : r_mem[w_top_idx];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (push && !full) begin
      r_count <= r_count + 1'b1;
    end else if (pop && !empty) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read below r_count.
  always_ff @(posedge clock) begin
    if (push && !full) begin
      r_mem[r_count[c_AW-1:0]] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bf_core_param.sv
`default_nettype none
// ============================================================================
//  Module   : bf_core_param
//  Purpose  : Parametrised Brainfuck-style tape-machine core. Fetches 3-bit
//             opcodes from a combinational program ROM, operates on a
//             combinational-read tape RAM, and exchanges characters over
//             valid/ready channels. Reports sticky halt and error status.
//  Config   : BF_CORE_LOOP_STACK_EN - when defined, a hardware loop stack
//             makes ']' back-jumps single-cycle; otherwise ']' rescans the
//             program backwards to find its matching '['.
//  Ports    : clock, reset_n (async active low)
//             pc / pmem_data_read           : program ROM address / opcode
//             sp / tape_data_read           : tape address / cell at sp
//             tape_we / tape_data_write     : one-cycle tape write at sp
//             out_valid/out_ready/out_data  : output character channel
//             in_valid/in_ready/in_data     : input character channel
//             halted, error                 : sticky terminal status
//  Revision : 1.0 - initial release
// ============================================================================
module bf_core_param
  import bf_pkg::*;
#(
  parameter int CELL_W       = 8,
  parameter int SP_W         = 16,
  parameter int PC_W         = 16,
  parameter int PROG_LEN     = 4096,
  parameter int STACK_DEPTH  = 16,
  parameter int SKIP_DEPTH_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [PC_W-1:0]   pc,
  input  logic [2:0]        pmem_data_read,
  output logic [SP_W-1:0]   sp,
  input  logic [CELL_W-1:0] tape_data_read,
  output logic              tape_we,
  output logic [CELL_W-1:0] tape_data_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CELL_W-1:0] out_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CELL_W-1:0] in_data,
  output logic              halted,
  output logic              error
);

  localparam logic [PC_W-1:0]         c_PROG_END  = PC_W'(PROG_LEN);
  localparam logic [SKIP_DEPTH_W-1:0] c_DEPTH_MAX = '1;
  localparam logic [SKIP_DEPTH_W-1:0] c_DEPTH_ONE = SKIP_DEPTH_W'(1);

  state_t                  r_state;
  opcode_t                 r_op;
  logic [CELL_W-1:0]       r_cell;
  logic [PC_W-1:0]         r_pc;
  logic [SP_W-1:0]         r_sp;
  logic [SKIP_DEPTH_W-1:0] r_depth;
  logic                    r_tape_we;
  logic [CELL_W-1:0]       r_tape_wdata;
  logic                    r_out_valid;
  logic [CELL_W-1:0]       r_out_data;
  logic                    r_in_ready;
  logic                    r_halted;
  logic                    r_error;

  opcode_t           w_rom_op;
  logic              w_cell_nz;
  logic              w_at_end;
  logic [CELL_W-1:0] w_fetch_cell;

  assign w_rom_op  = opcode_t'(pmem_data_read);
  assign w_cell_nz = (r_cell != '0);
  assign w_at_end  = (r_pc == c_PROG_END);

  // The registered tape write lands at the end of the FETCH cycle that
  // follows it, with sp unchanged, so the RAM still shows the old value.
  // Forward the pending write data instead.
  assign w_fetch_cell = r_tape_we ? r_tape_wdata : tape_data_read;

`ifdef BF_CORE_LOOP_STACK_EN
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [PC_W-1:0] w_top;

  assign w_push = (r_state == ST_EXEC) && (r_op == OP_LOOP) && w_cell_nz && !w_full;
  assign w_pop  = (r_state == ST_EXEC) && (r_op == OP_END) && !w_cell_nz;

  bf_loop_stack #(
    .PC_W  (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_loop_stack (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (r_pc),
    .top       (w_top),
    .full      (w_full),
    .empty     (w_empty)
  );
`else
  // The stack depth only matters when the loop stack is built.
  logic w_unused_cfg;
  assign w_unused_cfg = (STACK_DEPTH > 1);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_FETCH;
      r_op         <= OP_INC;
      r_cell       <= '0;
      r_pc         <= '0;
      r_sp         <= '0;
      r_depth      <= '0;
      r_tape_we    <= 1'b0;
      r_tape_wdata <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_in_ready   <= 1'b0;
      r_halted     <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_tape_we <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          if (w_at_end) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
            r_op    <= w_rom_op;
            r_cell  <= w_fetch_cell;
            r_state <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          r_state <= ST_FETCH;
          case (r_op)
            OP_INC: begin
              r_tape_we    <= 1'b1;
              r_tape_wdata <= r_cell + 1'b1;
              r_pc         <= r_pc + 1'b1;
            end
            OP_DEC: begin
              r_tape_we    <= 1'b1;
              r_tape_wdata <= r_cell - 1'b1;
              r_pc         <= r_pc + 1'b1;
            end
            OP_RIGHT: begin
              r_sp <= r_sp + 1'b1;
              r_pc <= r_pc + 1'b1;
            end
            OP_LEFT: begin
              r_sp <= r_sp - 1'b1;
              r_pc <= r_pc + 1'b1;
            end
            OP_LOOP: begin
              if (w_cell_nz) begin
`ifdef BF_CORE_LOOP_STACK_EN
                if (w_full) begin
                  r_state <= ST_ERROR;
                  r_error <= 1'b1;
                end else begin
                  r_pc <= r_pc + 1'b1;
                end
`else
                r_pc <= r_pc + 1'b1;
`endif
              end else begin
                r_depth <= c_DEPTH_ONE;
                r_pc    <= r_pc + 1'b1;
                r_state <= ST_SKIP_FWD;
              end
            end
            OP_END: begin
`ifdef BF_CORE_LOOP_STACK_EN
              if (w_cell_nz) begin
                if (w_empty) begin
                  r_state <= ST_ERROR;
                  r_error <= 1'b1;
                end else begin
                  r_pc <= w_top + 1'b1;
                end
              end else begin
                r_pc <= r_pc + 1'b1;
              end
`else
              if (w_cell_nz) begin
                if (r_pc == '0) begin
                  r_state <= ST_ERROR;
                  r_error <= 1'b1;
                end else begin
                  r_depth <= c_DEPTH_ONE;
                  r_pc    <= r_pc - 1'b1;
                  r_state <= ST_SKIP_BACK;
                end
              end else begin
                r_pc <= r_pc + 1'b1;
              end
`endif
            end
            OP_OUT: begin
              r_out_valid <= 1'b1;
              r_out_data  <= r_cell;
              r_state     <= ST_OUT_WAIT;
            end
            OP_IN: begin
              r_in_ready <= 1'b1;
              r_state    <= ST_IN_WAIT;
            end
            default: begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end
          endcase
        end

        // Forward scan for the ']' matching a skipped '['.
        ST_SKIP_FWD: begin
          if (w_at_end) begin
            r_state <= ST_ERROR;
            r_error <= 1'b1;
          end else begin
            case (w_rom_op)
              OP_LOOP: begin
                if (r_depth == c_DEPTH_MAX) begin
                  r_state <= ST_ERROR;
                  r_error <= 1'b1;
                end else begin
                  r_depth <= r_depth + 1'b1;
                  r_pc    <= r_pc + 1'b1;
                end
              end
              OP_END: begin
                r_depth <= r_depth - 1'b1;
                r_pc    <= r_pc + 1'b1;
                if (r_depth == c_DEPTH_ONE) begin
                  r_state <= ST_FETCH;
                end
              end
              default: r_pc <= r_pc + 1'b1;
            endcase
          end
        end

        // Backward scan for the '[' matching a taken ']'. Only reachable
        // without the loop stack.
        ST_SKIP_BACK: begin
`ifdef BF_CORE_LOOP_STACK_EN
          r_state <= ST_ERROR;
          r_error <= 1'b1;
`else
          case (w_rom_op)
            OP_END: begin
              if ((r_depth == c_DEPTH_MAX) || (r_pc == '0)) begin
                r_state <= ST_ERROR;
                r_error <= 1'b1;
              end else begin
                r_depth <= r_depth + 1'b1;
                r_pc    <= r_pc - 1'b1;
              end
            end
            OP_LOOP: begin
              if (r_depth == c_DEPTH_ONE) begin
                r_depth <= '0;
                r_pc    <= r_pc + 1'b1;
                r_state <= ST_FETCH;
              end else if (r_pc == '0) begin
                r_state <= ST_ERROR;
                r_error <= 1'b1;
              end else begin
                r_depth <= r_depth - 1'b1;
                r_pc    <= r_pc - 1'b1;
              end
            end
            default: begin
              if (r_pc == '0) begin
                r_state <= ST_ERROR;
                r_error <= 1'b1;
              end else begin
                r_pc <= r_pc - 1'b1;
              end
            end
          endcase
`endif
        end

        ST_OUT_WAIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_pc        <= r_pc + 1'b1;
            r_state     <= ST_FETCH;
          end
        end

        ST_IN_WAIT: begin
          if (in_valid) begin
            r_in_ready   <= 1'b0;
            r_tape_we    <= 1'b1;
            r_tape_wdata <= in_data;
            r_pc         <= r_pc + 1'b1;
            r_state      <= ST_FETCH;
          end
        end

        ST_HALT, ST_ERROR: begin
          r_state <= r_state;
        end

        default: begin
          r_state <= ST_ERROR;
          r_error <= 1'b1;
        end
      endcase
    end
  end

  assign pc              = r_pc;
  assign sp              = r_sp;
  assign tape_we         = r_tape_we;
  assign tape_data_write = r_tape_wdata;
  assign out_valid       = r_out_valid;
  assign out_data        = r_out_data;
  assign in_ready        = r_in_ready;
  assign halted          = r_halted;
  assign error           = r_error;

endmodule
`default_nettype wire

// File: tb/tb_bf_core_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bf_core_param
//  Purpose  : Scoreboard bench for bf_core_param. A program-level interpreter
//             predicts output characters, tape writes and final status; a
//             monitor compares DUT transfers against the expected queues.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bf_core_param;

  localparam int CELL_W       = 8;
  localparam int SP_W         = 8;
  localparam int PC_W         = 8;
  localparam int PROG_LEN     = 40;
  localparam int STACK_DEPTH  = 2;
  localparam int SKIP_DEPTH_W = 3;
  localparam int SKIP_MAX     = (1 << SKIP_DEPTH_W) - 1;
  localparam int MAX_STEPS    = 400;
`ifdef BF_CORE_LOOP_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [PC_W-1:0]   pc;
  logic [2:0]        pmem_data_read;
  logic [SP_W-1:0]   sp;
  logic [CELL_W-1:0] tape_data_read;
  logic              tape_we;
  logic [CELL_W-1:0] tape_data_write;
  logic              out_valid;
  logic              out_ready;
  logic [CELL_W-1:0] out_data;
  logic              in_valid;
  logic              in_ready;
  logic [CELL_W-1:0] in_data;
  logic              halted;
  logic              error;

  always #5 clock = ~clock;

  bf_core_param #(
    .CELL_W(CELL_W), .SP_W(SP_W), .PC_W(PC_W), .PROG_LEN(PROG_LEN),
    .STACK_DEPTH(STACK_DEPTH), .SKIP_DEPTH_W(SKIP_DEPTH_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .pc(pc), .pmem_data_read(pmem_data_read),
    .sp(sp), .tape_data_read(tape_data_read), .tape_we(tape_we),
    .tape_data_write(tape_data_write), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .halted(halted), .error(error)
  );

  // Program ROM and tape RAM, both combinational-read.
  logic [2:0] rom [PROG_LEN];
  logic [7:0] tape [256];
  bit         clr;

  assign pmem_data_read = (int'(pc) < PROG_LEN) ? rom[int'(pc)] : 3'd0;
  assign tape_data_read = tape[sp];

  always @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) tape[i] <= 8'h00;
    end else if (tape_we) begin
      tape[sp] <= tape_data_write;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  exp_out [$];
  logic [15:0] exp_wr  [$];
  logic [7:0]  in_q    [$];
  bit          m_halt, m_err;

  int cfg_delay = 0;
  int cfg_low   = 0;
  bit cfg_rdy   = 1'b1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference interpreter ----------------
  function automatic int match_fwd(input int from);
    int depth = 1;
    for (int p = from + 1; p < PROG_LEN; p++) begin
      if (rom[p] == 3'd4) begin
        if (depth == SKIP_MAX) return -1;
        depth++;
      end else if (rom[p] == 3'd5) begin
        depth--;
        if (depth == 0) return p;
      end
    end
    return -1;
  endfunction

  function automatic int match_back(input int from);
    int depth = 1;
    for (int p = from - 1; p >= 0; p--) begin
      if (rom[p] == 3'd5) begin
        if (depth == SKIP_MAX) return -1;
        depth++;
      end else if (rom[p] == 3'd4) begin
        depth--;
        if (depth == 0) return p;
      end
    end
    return -1;
  endfunction

  task automatic model_run(output bit ok);
    int pc_m = 0, sp_m = 0, steps = 0, inptr = 0, m;
    logic [7:0] t [256];
    int stk [$];
    for (int i = 0; i < 256; i++) t[i] = 8'h00;
    exp_out.delete(); exp_wr.delete();
    m_halt = 1'b0; m_err = 1'b0; ok = 1'b0;
    while (steps < MAX_STEPS) begin
      steps++;
      if (pc_m >= PROG_LEN) begin m_halt = 1'b1; ok = 1'b1; return; end
      case (rom[pc_m])
        3'd0: begin t[sp_m] = t[sp_m] + 8'd1; exp_wr.push_back({8'(sp_m), t[sp_m]}); pc_m++; end
        3'd1: begin t[sp_m] = t[sp_m] - 8'd1; exp_wr.push_back({8'(sp_m), t[sp_m]}); pc_m++; end
        3'd2: begin sp_m = (sp_m + 1) % 256; pc_m++; end
        3'd3: begin sp_m = (sp_m + 255) % 256; pc_m++; end
        3'd4: begin
          if (t[sp_m] != 0) begin
            if (STACK_EN && stk.size() >= STACK_DEPTH) begin m_err = 1'b1; ok = 1'b1; return; end
            if (STACK_EN) stk.push_back(pc_m);
            pc_m++;
          end else begin
            m = match_fwd(pc_m);
            if (m < 0) begin m_err = 1'b1; ok = 1'b1; return; end
            pc_m = m + 1;
          end
        end
        3'd5: begin
          if (t[sp_m] != 0) begin
            if (STACK_EN) begin
              if (stk.size() == 0) begin m_err = 1'b1; ok = 1'b1; return; end
              pc_m = stk[$] + 1;
            end else begin
              m = match_back(pc_m);
              if (m < 0) begin m_err = 1'b1; ok = 1'b1; return; end
              pc_m = m + 1;
            end
          end else begin
            if (STACK_EN && stk.size() > 0) void'(stk.pop_back());
            pc_m++;
          end
        end
        3'd6: begin exp_out.push_back(t[sp_m]); pc_m++; end
        default: begin
          if (inptr >= in_q.size()) return;  // would starve for input
          t[sp_m] = in_q[inptr];
          inptr++;
          exp_wr.push_back({8'(sp_m), t[sp_m]});
          pc_m++;
        end
      endcase
    end
  endtask

  // ---------------- program loading ----------------
  function automatic logic [2:0] op_of(input byte c);
    case (c)
      "+": return 3'd0;
      "-": return 3'd1;
      ">": return 3'd2;
      "<": return 3'd3;
      "[": return 3'd4;
      "]": return 3'd5;
      ".": return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  task automatic load_text(input string s);
    for (int i = 0; i < PROG_LEN; i++) rom[i] = (i < s.len()) ? op_of(s[i]) : 3'd2;
  endtask

  task automatic gen_random();
    int len = $urandom_range(6, PROG_LEN - 4);
    int depth = 0;
    int i = 0;
    int r;
    while (i < len - depth) begin
      r = $urandom_range(0, 11);
      if (r == 7 && depth < 3 && (i + depth + 2) <= len) begin rom[i] = 3'd4; depth++; end
      else if (r == 8 && depth > 0) begin rom[i] = 3'd5; depth--; end
      else if (r <= 2) rom[i] = 3'd0;
      else if (r == 3 || r == 4 || r == 11) rom[i] = 3'd1;
      else if (r == 5) rom[i] = 3'd2;
      else if (r == 6) rom[i] = 3'd3;
      else if (r == 9) rom[i] = 3'd6;
      else if (r == 10) rom[i] = 3'd7;
      else rom[i] = 3'd0;
      i++;
    end
    while (depth > 0) begin rom[i] = 3'd5; depth--; i++; end
    for (int k = i; k < PROG_LEN; k++) rom[k] = 3'd2;
    in_q.delete();
    for (int k = 0; k < 4; k++) in_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- input / output-ready driver ----------------
  initial begin : drv
    int idx = 0, dly = 0, lc = 0;
    bit fire;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    forever begin
      @(negedge clock);
      fire = in_valid && in_ready && reset_n;
      @(posedge clock);
      #1;
      if (!reset_n) begin
        idx = 0; dly = cfg_delay; lc = cfg_low; in_valid = 1'b0;
      end else if (fire) begin
        idx++; in_valid = 1'b0; dly = $urandom_range(0, 3);
      end else if (!in_valid) begin
        if (dly > 0) dly--;
        else if (idx < in_q.size()) begin in_valid = 1'b1; in_data = in_q[idx]; end
      end
      if (out_valid && lc > 0) begin out_ready = 1'b0; lc--; end
      else out_ready = cfg_rdy ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit         hold_pend;
  logic [7:0] hold_data;

  always @(negedge clock) begin
    if (!reset_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("out_hold_valid", 64'(out_valid), 64'd1);
        check("out_hold_data", 64'(out_data), 64'(hold_data));
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out_extra: got %0h expected no transfer", out_data);
        end else begin
          check("out_data", 64'(out_data), 64'(exp_out.pop_front()));
        end
      end
      if (tape_we) begin
        if (exp_wr.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL tape_extra: got sp=%0h data=%0h expected no write", sp, tape_data_write);
        end else begin
          check("tape_write", 64'({sp, tape_data_write}), 64'(exp_wr.pop_front()));
        end
      end
    end
  end

  // ---------------- run one program on the DUT ----------------
  task automatic reset_dut();
    reset_n = 1'b0;
    clr = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    clr = 1'b0;
  endtask

  task automatic run_dut(input string nm);
    int cyc = 0;
    reset_dut();
    check({nm, "_rst_state"},
          64'({pc, sp, tape_we, tape_data_write, out_valid, out_data, in_ready, halted, error}),
          64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    while (!(halted || error) && cyc < 20000) begin
      @(posedge clock);
      cyc++;
    end
    repeat (4) @(posedge clock);
    @(negedge clock);
    check({nm, "_finished"}, 64'(halted || error), 64'd1);
    check({nm, "_halted"}, 64'(halted), 64'(m_halt));
    check({nm, "_error"}, 64'(error), 64'(m_err));
    if (m_halt) check({nm, "_pc_end"}, 64'(pc), 64'(PROG_LEN));
    check({nm, "_out_left"}, 64'(exp_out.size()), 64'd0);
    check({nm, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
    check({nm, "_idle_io"}, 64'({out_valid, in_ready}), 64'd0);
    exp_out.delete();
    exp_wr.delete();
  endtask

  task automatic directed(input string nm, input string prog, input bit rdy,
                          input int dly, input int low);
    bit ok;
    load_text(prog);
    cfg_rdy = rdy; cfg_delay = dly; cfg_low = low;
    model_run(ok);
    check({nm, "_model_ok"}, 64'(ok), 64'd1);
    run_dut(nm);
  endtask

  initial begin : main
    bit ok;
    int cyc;
    clr = 1'b0;

    in_q.delete();
    directed("t1_inc3_out", "+++.", 1'b1, 0, 0);
    directed("t2_wrap_dec", "-.", 1'b1, 0, 0);
    directed("t3_move_loop", "++[>+<-]>.", 1'b1, 0, 0);
    directed("t4_skip_nested", "[+[+]].", 1'b1, 0, 0);
    in_q.push_back(8'h41);
    directed("t5_in_out", ",.", 1'b1, 7, 3);
    in_q.delete();
    directed("t6_deep_nest", "+[[[", 1'b1, 0, 0);
    directed("t6_lone_close", "+]", 1'b1, 0, 0);
    directed("t7_sp_wrap", "<+.", 1'b0, 0, 0);
    directed("t8_unmatched_open", "[", 1'b1, 0, 0);
    directed("t9_skip_overflow", "[[[[[[[[]]]]]]]]", 1'b1, 0, 0);
    directed("t10_two_loops", "+++[>++<-]>[-<+>]<.", 1'b0, 0, 0);

    // Reset while the core is stalled in an output transfer.
    load_text("+.");
    in_q.delete();
    cfg_rdy = 1'b1; cfg_delay = 0; cfg_low = 100000;
    model_run(ok);
    reset_dut();
    @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("rst_mid_out_valid_seen", 64'(out_valid), 64'd1);
    repeat (2) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_mid_out_cleared", 64'({out_valid, in_ready, tape_we, halted}), 64'd0);
    check("rst_mid_out_pc", 64'(pc), 64'd0);
    check("rst_mid_out_wr_done", 64'(exp_wr.size()), 64'd0);
    exp_out.delete();
    exp_wr.delete();
    cfg_low = 0;

    // Randomised programs with random I/O timing.
    for (int n = 0; n < 16; n++) begin
      ok = 1'b0;
      for (int tries = 0; tries < 50 && !ok; tries++) begin
        gen_random();
        model_run(ok);
      end
      if (ok) begin
        cfg_rdy = 1'b0;
        cfg_delay = $urandom_range(0, 6);
        cfg_low = 0;
        run_dut($sformatf("rand%0d", n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
